// File: rtl/scan_decoder.sv
// N-to-2^N registered decoder with direct select and a dwell-timed channel scanner.
// Outputs are registered only; Y_L and IDX always describe the same channel.
module scan_decoder #(
   parameter int N          = 3,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             G_L,
   input  logic             MODE,
   input  logic [N-1:0]     SEL,
   input  logic [N-1:0]     LAST,
   output logic [2**N-1:0]  Y_L,
   output logic [N-1:0]     IDX,
   output logic             WRAP
);

   localparam int M  = 2 ** N;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [DW-1:0] DMAX = DW'(DWELL - 1);
   localparam logic [M-1:0]  IDLE = ACTIVE_LOW ? {M{1'b1}} : {M{1'b0}};

   typedef enum logic [1:0] {
      DIRECT,
      SCAN_RUN,
      SCAN_PAUSE
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [DW-1:0]  dwell;
   logic [DW-1:0]  dwell_nx;
   logic [N-1:0]   idx_nx;
   logic [M-1:0]   y_nx;
   logic           wrap_nx;

   function automatic logic [M-1:0] decode(input logic [N-1:0] i);
      logic [M-1:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return ACTIVE_LOW ? ~oh : oh;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= DIRECT;
         dwell <= '0;
         IDX   <= '0;
         Y_L   <= IDLE;
         WRAP  <= 1'b0;
      end else begin
         state <= state_nx;
         dwell <= dwell_nx;
         IDX   <= idx_nx;
         Y_L   <= y_nx;
         WRAP  <= wrap_nx;
      end
   end

   // MODE = 0 dominates every state, including a pending advance or wrap.
   always_comb begin
      state_nx = state;
      dwell_nx = dwell;
      idx_nx   = IDX;
      y_nx     = IDLE;
      wrap_nx  = 1'b0;
      if (!MODE) begin
         state_nx = DIRECT;
         dwell_nx = '0;
         idx_nx   = SEL;
         y_nx     = G_L ? IDLE : decode(SEL);
      end else begin
         unique case (state)
            DIRECT: begin
               idx_nx   = '0;
               dwell_nx = '0;
               if (G_L) begin
                  state_nx = SCAN_PAUSE;
               end else begin
                  state_nx = SCAN_RUN;
                  y_nx     = decode('0);
               end
            end
            SCAN_RUN: begin
               // The pausing edge freezes index and dwell.
               if (G_L) begin
                  state_nx = SCAN_PAUSE;
               end else if (dwell == DMAX) begin
                  dwell_nx = '0;
                  if (IDX >= LAST) begin
                     idx_nx  = '0;
                     wrap_nx = 1'b1;
                  end else begin
                     idx_nx = IDX + 1'b1;
                  end
                  y_nx = decode(idx_nx);
               end else begin
                  dwell_nx = dwell + 1'b1;
                  y_nx     = decode(IDX);
               end
            end
            SCAN_PAUSE: begin
               // Resume edge only re-enables outputs; dwell stays held.
               if (!G_L) begin
                  state_nx = SCAN_RUN;
                  y_nx     = decode(IDX);
               end
            end
            default: begin
               state_nx = DIRECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: stimulus queues expectations,
// a monitor pops one entry per clock edge and compares three instances.
module tb_scan_decoder;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RESET = 1'b1;
   logic       G_L   = 1'b0;
   logic       MODE  = 1'b0;
   logic [2:0] SEL   = 3'd0;
   logic [2:0] LAST  = 3'd0;

   logic [7:0] y0, y1;
   logic [3:0] y2;
   logic [2:0] i0, i1;
   logic [1:0] i2;
   logic       w0, w1, w2;

   scan_decoder #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b1)) u0 (
      .CLK(CLK), .RESET(RESET), .G_L(G_L), .MODE(MODE),
      .SEL(SEL), .LAST(LAST), .Y_L(y0), .IDX(i0), .WRAP(w0)
   );

   scan_decoder #(.N(3), .DWELL(2), .ACTIVE_LOW(1'b1)) u1 (
      .CLK(CLK), .RESET(RESET), .G_L(G_L), .MODE(MODE),
      .SEL(SEL), .LAST(LAST), .Y_L(y1), .IDX(i1), .WRAP(w1)
   );

   scan_decoder #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b0)) u2 (
      .CLK(CLK), .RESET(RESET), .G_L(G_L), .MODE(MODE),
      .SEL(SEL[1:0]), .LAST(LAST[1:0]), .Y_L(y2), .IDX(i2), .WRAP(w2)
   );

   typedef struct {
      string      name;
      bit [2:0]   chk;
      logic [7:0] y[3];
      logic [2:0] idx[3];
      logic       w[3];
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   function automatic logic [7:0] lo(input int i);
      return ~(8'h01 << i);
   endfunction

   function automatic logic [7:0] hi(input int i);
      return 8'h01 << i;
   endfunction

   task automatic clr(input string n);
      e.name = n;
      e.chk  = '0;
   endtask

   task automatic want(input int d, input logic [7:0] y,
                       input int idx, input logic w);
      e.chk[d] = 1'b1;
      e.y[d]   = y;
      e.idx[d] = 3'(idx);
      e.w[d]   = w;
   endtask

   task automatic step(input logic r, input logic g, input logic m,
                       input int s, input int l);
      @(negedge CLK);
      RESET = r;
      G_L   = g;
      MODE  = m;
      SEL   = 3'(s);
      LAST  = 3'(l);
      q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (q.size() > 0) begin
            exp_t       x;
            logic [7:0] ay[3];
            logic [2:0] ai[3];
            logic       aw[3];
            x     = q.pop_front();
            ay[0] = y0;
            ay[1] = y1;
            ay[2] = {4'h0, y2};
            ai[0] = i0;
            ai[1] = i1;
            ai[2] = {1'b0, i2};
            aw[0] = w0;
            aw[1] = w1;
            aw[2] = w2;
            for (int d = 0; d < 3; d++) begin
               if (x.chk[d]) begin
                  total++;
                  if (ay[d] !== x.y[d] || ai[d] !== x.idx[d] ||
                      aw[d] !== x.w[d]) begin
                     bad++;
                     $display("FAIL %s u%0d @%0t: got y=%h idx=%0d wrap=%b, need y=%h idx=%0d wrap=%b",
                              x.name, d, $time, ay[d], ai[d], aw[d],
                              x.y[d], x.idx[d], x.w[d]);
                  end
               end
            end
         end
      end
   end

   initial begin
      int n;

      repeat (2) begin
         clr("reset");
         want(0, 8'hFF, 0, 1'b0);
         want(1, 8'hFF, 0, 1'b0);
         want(2, 8'h00, 0, 1'b0);
         step(1'b1, 1'b0, 1'b1, 0, 7);
      end

      clr("entry");
      want(0, 8'hFE, 0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 7);

      for (int k = 1; k <= 86; k++) begin
         int ix;
         ix = (k / 4) % 8;
         clr("full_scan");
         want(0, lo(ix), ix, (k % 32) == 0);
         step(1'b0, 1'b0, 1'b1, 0, 7);
      end

      clr("last_drop_hold");
      want(0, lo(5), 5, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 3);

      clr("last_drop_wrap");
      want(0, lo(0), 0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 0, 3);

      for (int j = 1; j <= 12; j++) begin
         int ix;
         ix = (j / 4) % 4;
         clr("last3_scan");
         want(0, lo(ix), ix, 1'b0);
         step(1'b0, 1'b0, 1'b1, 0, 3);
      end

      clr("pre_pause");
      want(0, lo(3), 3, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 7);

      repeat (5) begin
         clr("pause");
         want(0, 8'hFF, 3, 1'b0);
         step(1'b0, 1'b1, 1'b1, 0, 7);
      end

      repeat (3) begin
         clr("resume");
         want(0, lo(3), 3, 1'b0);
         step(1'b0, 1'b0, 1'b1, 0, 7);
      end

      clr("resume_adv");
      want(0, lo(4), 4, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 7);

      repeat (3) begin
         clr("hold4");
         want(0, lo(4), 4, 1'b0);
         step(1'b0, 1'b0, 1'b1, 0, 4);
      end

      clr("mode_vs_wrap");
      want(0, lo(6), 6, 1'b0);
      step(1'b0, 1'b0, 1'b0, 6, 4);

      for (int s = 0; s < 8; s++) begin
         clr("direct");
         want(0, lo(s), s, 1'b0);
         want(1, lo(s), s, 1'b0);
         want(2, hi(s % 4), s % 4, 1'b0);
         step(1'b0, 1'b0, 1'b0, s, 0);
      end

      clr("gated");
      want(0, 8'hFF, 5, 1'b0);
      want(2, 8'h00, 1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 5, 0);

      for (int j = 0; j <= 13; j++) begin
         int a, b;
         a = (j / 2) % 3;
         b = (j / 4) % 3;
         clr("short_scan");
         want(1, lo(a), a, (j > 0) && (j % 6 == 0));
         want(0, lo(b), b, (j > 0) && (j % 12 == 0));
         step(1'b0, 1'b0, 1'b1, 0, 2);
      end

      clr("reset_mid");
      want(0, 8'hFF, 0, 1'b0);
      want(1, 8'hFF, 0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 0, 2);

      clr("reentry");
      want(1, lo(0), 0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 0, 2);

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge CLK);
         #2;
         n++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, need 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
